note_display_sched: RTL

Sequencer and arbiter for the single 7-segment note decoder (`show_key`). It shares that decoder between two requesters: live keyboard presses and the playback stream from the beat recorder. It holds each note on the display for a fixed time, then inserts a blank gap. Live input has priority and preempts playback.

---
 rtl/beat_pkg.sv | 37 +++
 rtl/note_key_filter.sv | 18 +
 rtl/note_display_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/beat_pkg.sv
// Shared constants for the note display path: legal note codes, blank code, FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package beat_pkg;

  // Legal note keys (ASCII upper case); everything else is rejected
  localparam logic [6:0] KEY_A = 7'd65;
  localparam logic [6:0] KEY_B = 7'd66;
  localparam logic [6:0] KEY_C = 7'd67;
  localparam logic [6:0] KEY_D = 7'd68;
  localparam logic [6:0] KEY_E = 7'd69;
  localparam logic [6:0] KEY_F = 7'd70;
  localparam logic [6:0] KEY_G = 7'd71;
  localparam logic [6:0] KEY_H = 7'd72;
  localparam logic [6:0] KEY_J = 7'd74;
  localparam logic [6:0] KEY_K = 7'd75;
  localparam logic [6:0] KEY_M = 7'd77;
  localparam logic [6:0] KEY_N = 7'd78;
  localparam logic [6:0] KEY_S = 7'd83;
  localparam logic [6:0] KEY_T = 7'd84;
  localparam logic [6:0] KEY_U = 7'd85;
  localparam logic [6:0] KEY_V = 7'd86;
  localparam logic [6:0] KEY_W = 7'd87;
  localparam logic [6:0] KEY_X = 7'd88;
  localparam logic [6:0] KEY_Y = 7'd89;
  localparam logic [6:0] KEY_Z = 7'd90;

  // Code that makes show_key drive all segments off
  localparam logic [6:0] ASCII_BLANK = 7'd0;

  // Scheduler FSM encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SHOW_LIVE = 2'd1;
  localparam logic [1:0] ST_SHOW_PB   = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

endpackage

// File: rtl/note_key_filter.sv
// Flags whether a 7-bit ASCII code is one of the 20 legal note keys.
// Latency: purely combinational.
// Backpressure: none.
module note_key_filter
  import beat_pkg::*;
(
  input  logic [6:0] code,
  output logic       legal
);

  // Set membership against the legal key table
  always_comb begin
    legal = code inside {KEY_A, KEY_B, KEY_C, KEY_D, KEY_E, KEY_F, KEY_G, KEY_H,
                         KEY_J, KEY_K, KEY_M, KEY_N,
                         KEY_S, KEY_T, KEY_U, KEY_V, KEY_W, KEY_X, KEY_Y, KEY_Z};
  end

endmodule

// File: rtl/note_display_sched.sv
// Shares the 7-seg note decoder between live key presses and playback; holds each note, then blanks.
// Latency: live press -> display 2 cycles; playback accept -> display 1 cycle.
// Backpressure: pb_ready only in IDLE with no pending live note and no live press; live always wins.
module note_display_sched
  import beat_pkg::*;
#(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       live_valid,
  input  logic [6:0] live_ascii,
  input  logic       pb_valid,
  input  logic [6:0] pb_ascii,
  output logic       pb_ready,
  output logic [6:0] ascii_val,
  output logic       src_pb,
  output logic       busy,
  output logic       note_done,
  output logic       bad_key
);

  // One shared down-counter covers both the hold and the gap phase
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       ascii_q, ascii_d;
  logic             src_pb_q, src_pb_d;
  logic             pend_q, pend_d;
  logic [6:0]       pend_ascii_q, pend_ascii_d;
  logic             note_done_q, note_done_d;
  logic             bad_key_q, bad_key_d;

  logic live_legal;
  logic pb_legal;

  note_key_filter u_live_filter (
    .code  (live_ascii),
    .legal (live_legal)
  );

  note_key_filter u_pb_filter (
    .code  (pb_ascii),
    .legal (pb_legal)
  );

  // Next-state: FSM sequencing first, then live capture so a fresh press always survives
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ascii_d      = ascii_q;
    src_pb_d     = src_pb_q;
    pend_d       = pend_q;
    pend_ascii_d = pend_ascii_q;
    note_done_d  = 1'b0;
    bad_key_d    = 1'b0;
    pb_ready     = 1'b0;

    if (pend_q) begin
      // A pending live note wins from every state, preempting without a gap
      state_d  = ST_SHOW_LIVE;
      ascii_d  = pend_ascii_q;
      src_pb_d = 1'b0;
      cnt_d    = HOLD_LOAD;
      pend_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A same-cycle live press holds playback off so the press is shown first
          pb_ready = pb_valid & ~live_valid;
          if (pb_ready) begin
            if (pb_legal) begin
              state_d  = ST_SHOW_PB;
              ascii_d  = pb_ascii;
              src_pb_d = 1'b1;
              cnt_d    = HOLD_LOAD;
            end else begin
              // Illegal beat is consumed and dropped
              bad_key_d = 1'b1;
            end
          end
        end
        ST_SHOW_LIVE, ST_SHOW_PB: begin
          if (cnt_q == '0) begin
            state_d     = ST_GAP;
            ascii_d     = ASCII_BLANK;
            cnt_d       = GAP_LOAD;
            note_done_d = (state_q == ST_SHOW_PB);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ascii_d = ASCII_BLANK;
          cnt_d   = '0;
        end
      endcase
    end

    // Live capture runs in every state; newest legal press overwrites older ones
    if (live_valid) begin
      if (live_legal) begin
        pend_d       = 1'b1;
        pend_ascii_d = live_ascii;
      end else begin
        bad_key_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset; reset blanks the display immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ascii_q      <= ASCII_BLANK;
      src_pb_q     <= 1'b0;
      pend_q       <= 1'b0;
      pend_ascii_q <= ASCII_BLANK;
      note_done_q  <= 1'b0;
      bad_key_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ascii_q      <= ascii_d;
      src_pb_q     <= src_pb_d;
      pend_q       <= pend_d;
      pend_ascii_q <= pend_ascii_d;
      note_done_q  <= note_done_d;
      bad_key_q    <= bad_key_d;
    end
  end

  assign ascii_val = ascii_q;
  assign src_pb    = src_pb_q;
  assign busy      = (state_q != ST_IDLE);
  assign note_done = note_done_q;
  assign bad_key   = bad_key_q;

endmodule
